// File: rtl/assignment.sv
// Four-word flip-flop register file with a single shared write/read port.
// Loads write through to the registered output; reads return the selected word one edge later.
module assignment #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic [AW-1:0]    sel,
    input  logic [WIDTH-1:0] memin,
    output logic [WIDTH-1:0] memout,
    input  logic             clk,
    input  logic             ld,
    input  logic             rst
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Reset clears storage and output alike and wins over a pending load.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            memout <= '0;
        end else if (ld) begin
            mem[sel] <= memin;
            memout   <= memin;
        end else begin
            memout <= mem[sel];
        end
    end

endmodule

// File: tb/tb_assignment.sv
// Directed plus randomized checks of the register file against a word-array reference model.
module tb_assignment;

    logic [1:0] sel;
    logic [5:0] memin;
    logic [5:0] memout;
    logic       clk;
    logic       ld;
    logic       rst;

    int checks   = 0;
    int failures = 0;

    logic [5:0] model [4];
    logic [5:0] model_out;

    assignment #(.WIDTH(6), .DEPTH(4), .AW(2)) dut (
        .sel    (sel),
        .memin  (memin),
        .memout (memout),
        .clk    (clk),
        .ld     (ld),
        .rst    (rst)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [5:0] exp);
        checks++;
        assert (memout === exp) else begin
            failures++;
            $error("FAIL %s: memout=%0d expected=%0d", tag, memout, exp);
        end
    endtask

    // Apply one set of inputs for 'hold' edges; after each edge update the model and compare.
    task automatic step(input logic r, input logic l, input logic [1:0] s,
                        input logic [5:0] d, input int hold, input string tag);
        rst   = r;
        ld    = l;
        sel   = s;
        memin = d;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (r) begin
                for (int i = 0; i < 4; i++) model[i] = 6'd0;
                model_out = 6'd0;
            end else if (l) begin
                model[s]  = d;
                model_out = d;
            end else begin
                model_out = model[s];
            end
            check(tag, model_out);
        end
    endtask

    initial begin
        logic [5:0] wr_data [7];
        logic [1:0] wr_sel  [7];
        logic [5:0] rb_exp  [4];
        logic       r_r;
        logic       r_l;
        logic [1:0] r_s;
        logic [5:0] r_d;

        wr_sel  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
        wr_data = '{6'd3, 6'd4, 6'd5, 6'd6, 6'd5, 6'd2, 6'd1};
        rb_exp  = '{6'd1, 6'd5, 6'd2, 6'd6};

        for (int i = 0; i < 4; i++) model[i] = 'x;
        model_out = 'x;
        rst = 1'b0; ld = 1'b0; sel = 2'd0; memin = 6'd0;
        @(negedge clk);

        // 1: reset with a pending load of 63, then all words read zero
        step(1'b1, 1'b1, 2'd0, 6'd63, 1, "reset_edge1");
        check("reset_edge1_const", 6'd0);
        step(1'b1, 1'b1, 2'd0, 6'd63, 1, "reset_edge2");
        check("reset_edge2_const", 6'd0);
        for (int a = 0; a < 4; a++) begin
            step(1'b0, 1'b0, 2'(a), 6'd0, 1, "reset_read");
            check("reset_read_const", 6'd0);
        end

        // 2: write-through sequence, each step held three edges
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, wr_sel[i], wr_data[i], 3, "write_through");
            check("write_through_const", wr_data[i]);
        end

        // 3: readback of final contents
        for (int a = 0; a < 4; a++) begin
            step(1'b0, 1'b0, 2'(a), 6'd0, 1, "readback");
            check("readback_const", rb_exp[a]);
        end

        // 4: isolation of a single write
        step(1'b0, 1'b1, 2'd2, 6'd42, 1, "iso_write");
        step(1'b0, 1'b0, 2'd0, 6'd0, 1, "iso_read0");
        check("iso_read0_const", 6'd1);
        step(1'b0, 1'b0, 2'd1, 6'd0, 1, "iso_read1");
        check("iso_read1_const", 6'd5);
        step(1'b0, 1'b0, 2'd3, 6'd0, 1, "iso_read3");
        check("iso_read3_const", 6'd6);
        step(1'b0, 1'b0, 2'd2, 6'd0, 1, "iso_read2");
        check("iso_read2_const", 6'd42);

        // 5: reset in the middle of a load sequence
        step(1'b1, 1'b1, 2'd3, 6'd7, 1, "mid_reset");
        check("mid_reset_const", 6'd0);
        step(1'b0, 1'b0, 2'd3, 6'd7, 1, "mid_reset_word3");
        check("mid_reset_word3_const", 6'd0);
        step(1'b0, 1'b1, 2'd3, 6'd7, 1, "post_reset_load");
        check("post_reset_load_const", 6'd7);
        step(1'b0, 1'b0, 2'd0, 6'd0, 1, "post_reset_word0");
        check("post_reset_word0_const", 6'd0);

        // 6: back-to-back load then read of the same word
        step(1'b0, 1'b1, 2'd1, 6'd9, 1, "b2b_load");
        check("b2b_load_const", 6'd9);
        step(1'b0, 1'b0, 2'd1, 6'd0, 1, "b2b_read");
        check("b2b_read_const", 6'd9);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            r_r = ($urandom_range(0, 24) == 0);
            r_l = $urandom_range(0, 1) == 1;
            r_s = 2'($urandom_range(0, 3));
            r_d = 6'($urandom_range(0, 63));
            step(r_r, r_l, r_s, r_d, 1, "random");
        end

        // Final sweep of all words against the model
        for (int a = 0; a < 4; a++) begin
            step(1'b0, 1'b0, 2'(a), 6'd0, 1, "final_sweep");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
